// File: rtl/sequence_encode_pkg.sv
// Shared ISO/IEC 14443A definitions: PICC bit-sequence encoding and the
// default 106 kbit/s timing constants used by both transmit and receive paths.
package ISO14443A_pkg;

    typedef enum logic [1:0] {
        PICCBitSequence_D = 2'd0,
        PICCBitSequence_E = 2'd1,
        PICCBitSequence_F = 2'd2
    } PICCBitSequence;

    localparam int ISO14443A_BIT_CLKS       = 128;
    localparam int ISO14443A_SUBCARRIER_DIV = 16;

    typedef enum logic {
        ENC_IDLE = 1'b0,
        ENC_RUN  = 1'b1
    } enc_state_e;

endpackage

// File: rtl/sequence_encode_buffer.sv
// One-entry holding register that lets the next PICC sequence be queued
// while the current bit is still being transmitted.
module sequence_encode_buffer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       pop_i,
    input  logic [1:0] seq_i,
    output logic [1:0] nxt_seq_o,
    output logic       nxt_valid_o
);

    logic [1:0] nxt_seq_q;
    logic       nxt_valid_q;

    // load and pop are mutually exclusive: load needs an empty entry, pop a full one.
    always_ff @(posedge clk) begin
        if (rst) begin
            nxt_seq_q   <= 2'd2;
            nxt_valid_q <= 1'b0;
        end else if (load_i) begin
            nxt_seq_q   <= seq_i;
            nxt_valid_q <= 1'b1;
        end else if (pop_i) begin
            nxt_valid_q <= 1'b0;
        end
    end

    assign nxt_seq_o   = nxt_seq_q;
    assign nxt_valid_o = nxt_valid_q;

endmodule

// File: rtl/sequence_encode.sv
// ISO/IEC 14443A PICC->PCD sequence encoder (D/E/F -> load modulation).
// Define SEQUENCE_ENCODE_SUBCARRIER_EN to put the fc/16 subcarrier on lm_out;
// otherwise lm_out is the modulation envelope only.
// Handshake: a sequence transfers on any rising edge with seq_valid && seq_ready;
// the source holds seq/seq_valid stable until then.
module sequence_encode
    import ISO14443A_pkg::*;
#(
    parameter int BIT_CLKS       = ISO14443A_BIT_CLKS,
    parameter int SUBCARRIER_DIV = ISO14443A_SUBCARRIER_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] seq,
    input  logic       seq_valid,
    output logic       seq_ready,
    output logic       lm_out,
    output logic       seq_done,
    output logic       idle,
    output logic       dbg_state_o
);

    localparam int CW = ($clog2(BIT_CLKS) > $clog2(SUBCARRIER_DIV)) ?
                        $clog2(BIT_CLKS) : $clog2(SUBCARRIER_DIV);
    localparam logic [CW-1:0] LAST = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] HALF = CW'(BIT_CLKS / 2);

    enc_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    cur_seq_q;
    logic          lm_q;
    logic          lm_d;

    logic [1:0] nxt_seq;
    logic       nxt_valid;
    logic       accept;
    logic       bit_end;
    logic       modulated;

    assign seq_ready = !nxt_valid;
    assign accept    = seq_valid && seq_ready;
    assign bit_end   = (state_q == ENC_RUN) && (cnt_q == LAST);

    sequence_encode_buffer u_buffer (
        .clk         (clk),
        .rst         (rst),
        .load_i      (accept && (state_q == ENC_RUN) && (cnt_q != LAST)),
        .pop_i       (bit_end && nxt_valid),
        .seq_i       (seq),
        .nxt_seq_o   (nxt_seq),
        .nxt_valid_o (nxt_valid)
    );

    // Illegal encodings fall through as unmodulated, i.e. sent as F.
    assign modulated = ((cur_seq_q == PICCBitSequence_D) && (cnt_q <  HALF)) ||
                       ((cur_seq_q == PICCBitSequence_E) && (cnt_q >= HALF));

`ifdef SEQUENCE_ENCODE_SUBCARRIER_EN
    localparam int SC_BIT = $clog2(SUBCARRIER_DIV) - 1;
    logic sc;
    assign sc   = ~cnt_q[SC_BIT];
    assign lm_d = (state_q == ENC_RUN) && modulated && sc;
`else
    assign lm_d = (state_q == ENC_RUN) && modulated;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ENC_IDLE;
            cnt_q     <= '0;
            cur_seq_q <= PICCBitSequence_F;
            lm_q      <= 1'b0;
        end else begin
            lm_q <= lm_d;
            case (state_q)
                ENC_IDLE: begin
                    if (accept) begin
                        cur_seq_q <= seq;
                        cnt_q     <= '0;
                        state_q   <= ENC_RUN;
                    end
                end
                ENC_RUN: begin
                    if (cnt_q == LAST) begin
                        // Buffered sequence first, then a same-cycle accept, so bits stay contiguous.
                        cnt_q <= '0;
                        if (nxt_valid) begin
                            cur_seq_q <= nxt_seq;
                        end else if (accept) begin
                            cur_seq_q <= seq;
                        end else begin
                            state_q <= ENC_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ENC_IDLE;
            endcase
        end
    end

    assign lm_out      = lm_q;
    assign seq_done    = bit_end;
    assign idle        = (state_q == ENC_IDLE) && !nxt_valid;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sequence_encode.sv
// Directed bench for sequence_encode: reset, single D, back-to-back, bit-end
// accept, underrun, mid-bit reset and illegal encoding.
module tb_sequence_encode;
    import ISO14443A_pkg::*;

    localparam int BC = 128;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] seq = 2'd0;
    logic       seq_valid = 1'b0;
    logic       seq_ready;
    logic       lm_out;
    logic       seq_done;
    logic       idle;
    logic       dbg_state_o;

    int checks = 0;
    int errors = 0;

    logic [1:0] src_q[$];
    int         at_q[$];
    logic       lm_cap[$];
    logic       done_cap[$];
    logic       idle_cap[$];
    logic       ready_cap[$];

    sequence_encode dut (
        .clk         (clk),
        .rst         (rst),
        .seq         (seq),
        .seq_valid   (seq_valid),
        .seq_ready   (seq_ready),
        .lm_out      (lm_out),
        .seq_done    (seq_done),
        .idle        (idle),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clk = ~clk;

    // Expected lm_out over one bit; bit i corresponds to counter value i.
    function automatic logic [BC-1:0] exp_bits(input logic [1:0] s);
        logic [BC-1:0] v;
        for (int i = 0; i < BC; i++) begin
            logic m;
            m = ((s == 2'd0) && (i < BC/2)) || ((s == 2'd1) && (i >= BC/2));
`ifdef SEQUENCE_ENCODE_SUBCARRIER_EN
            v[i] = m && ((i % 16) < 8);
`else
            v[i] = m;
`endif
        end
        return v;
    endfunction

    function automatic logic [BC-1:0] cap_vec(input int start);
        logic [BC-1:0] v;
        for (int i = 0; i < BC; i++)
            v[i] = (start + i < lm_cap.size()) ? lm_cap[start + i] : 1'bx;
        return v;
    endfunction

    function automatic int count_hi(input logic q[$], input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++)
            if (i < q.size() && q[i] === 1'b1) n++;
        return n;
    endfunction

    // Runs ncyc cycles; sample k is taken at the negedge after the k-th posedge
    // from the start. Sources in src_q are offered from sample at_q onwards.
    task automatic run_stream(input int ncyc, input int rst_at);
        lm_cap.delete(); done_cap.delete(); idle_cap.delete(); ready_cap.delete();
        seq_valid = (src_q.size() > 0) ? (at_q[0] <= 0) : 1'b0;
        seq       = (src_q.size() > 0) ? src_q[0] : 2'd0;
        for (int c = 0; c < ncyc; c++) begin
            logic acc;
            @(negedge clk);
            lm_cap.push_back(lm_out);
            done_cap.push_back(seq_done);
            idle_cap.push_back(idle);
            ready_cap.push_back(seq_ready);
            acc = seq_valid && seq_ready && !rst;
            @(posedge clk);
            #1;
            if (acc) begin
                void'(src_q.pop_front());
                void'(at_q.pop_front());
            end
            rst       = (c == rst_at);
            seq_valid = (src_q.size() > 0) ? (at_q[0] <= c + 1) : 1'b0;
            seq       = (src_q.size() > 0) ? src_q[0] : 2'd0;
        end
        seq_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (lm_out !== 1'b0) begin errors++; $display("FAIL reset_lm: got %b exp 0", lm_out); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b exp 1", idle); end
        checks++; if (seq_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", seq_ready); end
        checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", seq_done); end
        checks++; if (dbg_state_o !== 1'b0) begin errors++; $display("FAIL reset_state: got %b exp 0", dbg_state_o); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single_d();
        logic [BC-1:0] exp_d;
`ifdef SEQUENCE_ENCODE_SUBCARRIER_EN
        exp_d = {64'h0, 64'h00FF_00FF_00FF_00FF};
`else
        exp_d = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
`endif
        src_q = '{2'd0}; at_q = '{0};
        run_stream(140, -1);
        checks++; if (idle_cap[0] !== 1'b1) begin errors++; $display("FAIL single_idle_before: got %b exp 1", idle_cap[0]); end
        checks++; if (idle_cap[1] !== 1'b0) begin errors++; $display("FAIL single_idle_falls: got %b exp 0", idle_cap[1]); end
        checks++; if (lm_cap[1] !== 1'b0) begin errors++; $display("FAIL single_latency: got %b exp 0", lm_cap[1]); end
        checks++; if (cap_vec(2) !== exp_d) begin errors++; $display("FAIL single_d_lm: got %h exp %h", cap_vec(2), exp_d); end
        checks++; if (done_cap[128] !== 1'b1) begin errors++; $display("FAIL single_done_at_127: got %b exp 1", done_cap[128]); end
        checks++; if (count_hi(done_cap, 0, 139) !== 1) begin errors++; $display("FAIL single_done_count: got %0d exp 1", count_hi(done_cap, 0, 139)); end
        checks++; if (idle_cap[128] !== 1'b0) begin errors++; $display("FAIL single_idle_last: got %b exp 0", idle_cap[128]); end
        checks++; if (idle_cap[129] !== 1'b1) begin errors++; $display("FAIL single_idle_rises: got %b exp 1", idle_cap[129]); end
        checks++; if (count_hi(lm_cap, 130, 139) !== 0) begin errors++; $display("FAIL single_lm_after: got %0d highs exp 0", count_hi(lm_cap, 130, 139)); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] order [4];
        order = '{2'd0, 2'd1, 2'd2, 2'd0};
        src_q = '{2'd0, 2'd1, 2'd2, 2'd0}; at_q = '{0, 0, 0, 0};
        run_stream(530, -1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cap_vec(2 + k*BC) !== exp_bits(order[k])) begin
                errors++; $display("FAIL b2b_lm_seq%0d: got %h exp %h", k, cap_vec(2 + k*BC), exp_bits(order[k]));
            end
        end
        checks++; if (ready_cap[1] !== 1'b1) begin errors++; $display("FAIL b2b_ready_empty: got %b exp 1", ready_cap[1]); end
        checks++; if (ready_cap[2] !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b exp 0", ready_cap[2]); end
        checks++; if (ready_cap[129] !== 1'b1) begin errors++; $display("FAIL b2b_ready_pop: got %b exp 1", ready_cap[129]); end
        checks++; if (count_hi(idle_cap, 1, 512) !== 0) begin errors++; $display("FAIL b2b_no_gap: got %0d idle cycles exp 0", count_hi(idle_cap, 1, 512)); end
        checks++; if (count_hi(done_cap, 0, 529) !== 4) begin errors++; $display("FAIL b2b_done_count: got %0d exp 4", count_hi(done_cap, 0, 529)); end
        checks++; if (idle_cap[513] !== 1'b1) begin errors++; $display("FAIL b2b_idle_end: got %b exp 1", idle_cap[513]); end
        checks++; if (count_hi(lm_cap, 514, 529) !== 0) begin errors++; $display("FAIL b2b_lm_tail: got %0d highs exp 0", count_hi(lm_cap, 514, 529)); end
    endtask

    task automatic test_bit_end_accept();
        src_q = '{2'd0, 2'd1}; at_q = '{0, 128};
        run_stream(270, -1);
        checks++; if (ready_cap[128] !== 1'b1) begin errors++; $display("FAIL bitend_ready: got %b exp 1", ready_cap[128]); end
        checks++; if (idle_cap[129] !== 1'b0) begin errors++; $display("FAIL bitend_no_idle: got %b exp 0", idle_cap[129]); end
        checks++; if (cap_vec(2) !== exp_bits(2'd0)) begin errors++; $display("FAIL bitend_d: got %h exp %h", cap_vec(2), exp_bits(2'd0)); end
        checks++; if (cap_vec(130) !== exp_bits(2'd1)) begin errors++; $display("FAIL bitend_e: got %h exp %h", cap_vec(130), exp_bits(2'd1)); end
        checks++; if (idle_cap[257] !== 1'b1) begin errors++; $display("FAIL bitend_idle_end: got %b exp 1", idle_cap[257]); end
    endtask

    task automatic test_underrun();
        src_q = '{2'd1, 2'd0}; at_q = '{0, 200};
        run_stream(340, -1);
        checks++; if (cap_vec(2) !== exp_bits(2'd1)) begin errors++; $display("FAIL underrun_e: got %h exp %h", cap_vec(2), exp_bits(2'd1)); end
        checks++; if (count_hi(idle_cap, 129, 200) !== 72) begin errors++; $display("FAIL underrun_idle: got %0d exp 72", count_hi(idle_cap, 129, 200)); end
        checks++; if (count_hi(lm_cap, 130, 201) !== 0) begin errors++; $display("FAIL underrun_lm_low: got %0d highs exp 0", count_hi(lm_cap, 130, 201)); end
        checks++; if (idle_cap[201] !== 1'b0) begin errors++; $display("FAIL underrun_restart: got %b exp 0", idle_cap[201]); end
        checks++; if (cap_vec(202) !== exp_bits(2'd0)) begin errors++; $display("FAIL underrun_d: got %h exp %h", cap_vec(202), exp_bits(2'd0)); end
    endtask

    task automatic test_mid_reset();
        logic [BC-1:0] exp_d;
        logic [BC-1:0] got_d;
        exp_d = exp_bits(2'd0);
        got_d = cap_vec(0);
        src_q = '{2'd0, 2'd1}; at_q = '{0, 0};
        run_stream(240, 40);
        got_d = cap_vec(2);
        checks++; if (got_d[39:0] !== exp_d[39:0]) begin errors++; $display("FAIL rst_prefix: got %h exp %h", got_d[39:0], exp_d[39:0]); end
        checks++; if (ready_cap[41] !== 1'b0) begin errors++; $display("FAIL rst_buffered: got %b exp 0", ready_cap[41]); end
        checks++; if (lm_cap[42] !== 1'b0) begin errors++; $display("FAIL rst_lm: got %b exp 0", lm_cap[42]); end
        checks++; if (idle_cap[42] !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b exp 1", idle_cap[42]); end
        checks++; if (ready_cap[42] !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", ready_cap[42]); end
        checks++; if (count_hi(lm_cap, 42, 239) !== 0) begin errors++; $display("FAIL rst_no_e: got %0d highs exp 0", count_hi(lm_cap, 42, 239)); end
        checks++; if (count_hi(done_cap, 0, 239) !== 0) begin errors++; $display("FAIL rst_no_done: got %0d exp 0", count_hi(done_cap, 0, 239)); end
    endtask

    task automatic test_illegal();
        src_q = '{2'd3}; at_q = '{0};
        run_stream(140, -1);
        checks++; if (idle_cap[1] !== 1'b0) begin errors++; $display("FAIL illegal_run: got %b exp 0", idle_cap[1]); end
        checks++; if (count_hi(lm_cap, 0, 139) !== 0) begin errors++; $display("FAIL illegal_lm: got %0d highs exp 0", count_hi(lm_cap, 0, 139)); end
        checks++; if (count_hi(done_cap, 0, 139) !== 1) begin errors++; $display("FAIL illegal_done: got %0d exp 1", count_hi(done_cap, 0, 139)); end
    endtask

    initial begin
        test_reset();
        test_single_d();
        test_back_to_back();
        test_bit_end_accept();
        test_underrun();
        test_mid_reset();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
